ringbuffer_drain: RTL and testbench
===================================

Name: ringbuffer_drain

Overview:
Read-side consumer of the sniffer ring buffer. Pops captured LPC frames (DW bits each) whenever the buffer is non-empty. Each frame is serialized as one header byte followed by DW/8 payload bytes, MSB first, into the byte-wide UART transmitter. Sits between the ring buffer read port and uart_tx; reports buffer overflow in-band through the header byte.

Parameters:
DW, 48, ring buffer entry width in bits; must be a multiple of 8 and at least 8.
HDR_OK, 8'hA5, header byte for a frame captured with no intervening overflow.
HDR_OVF, 8'h5A, header byte for the first frame sent after an overflow was seen.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  when low, no new frame is popped; a frame already in progress completes
rb_empty  input  1  ring buffer empty flag
rb_overflow  input  1  ring buffer overflow (full) flag
rb_read_data  input  DW  ring buffer read data; registered, valid the cycle after the pop
rb_read_enable  output  1  one-cycle pop strobe to the ring buffer
tx_busy  input  1  UART transmitter busy
tx_start  output  1  one-cycle start strobe to the UART
tx_data  output  8  byte to transmit; stable while tx_start is high
active  output  1  high from pop until the last byte has been handed off
frame_count  output  16  frames fully handed to the UART; wraps at 16'hFFFF -> 0

Behaviour:
- Reset (synchronous, active-high, takes priority over all other logic):
  - state=IDLE; rb_read_enable=0, tx_start=0, tx_data=0, active=0, frame_count=0.
  - Overflow-sticky flag cleared; shift register and byte counter cleared.
  - Reset asserted mid-frame abandons the frame. The partially sent frame is not counted and no further bytes are emitted.
- State machine (one-hot or binary; states IDLE, POP, LATCH, SEND, ACK, WAIT):
  - IDLE: if enable & ~rb_empty, assert rb_read_enable for exactly one cycle and go to POP. active goes high in the same cycle.
  - POP: rb_read_data becomes valid at the end of this cycle. Go to LATCH.
  - LATCH: load the shift register with rb_read_data. Load the byte counter with DW/8. Select the header byte: HDR_OVF if the sticky flag is set, else HDR_OK. Clear the sticky flag unless rb_overflow is high this cycle. Go to SEND.
  - SEND: wait while tx_busy. When ~tx_busy, drive tx_data = current byte and tx_start=1 for one cycle, then go to ACK.
  - ACK: one cycle, tx_busy ignored; uart_tx raises busy the cycle after start. Go to WAIT.
  - WAIT: when ~tx_busy, proceed. If bytes remain, shift left by 8, decrement the counter and go to SEND. Otherwise increment frame_count, drop active and go to IDLE.
- Byte order: header first, then rb_read_data[DW-1:DW-8], ..., [7:0]. DW=48 gives 7 UART bytes per frame.
- Overflow sticky flag:
  - Set on any cycle rb_overflow=1.
  - Cleared only when consumed in LATCH. Simultaneous set and consume leaves it set.
- rb_read_enable is never asserted when rb_empty=1, and never more than once per frame.
- Throughput: minimum frame cost is 3 + 3*(DW/8+1) cycles excluding UART time. IDLE→POP is permitted in the cycle after WAIT→IDLE.
- enable deasserted mid-frame: the frame completes; no further pop occurs until enable returns.

Decomposition:
- Shared package lpc_sniffer_pkg: state encoding constants, HDR_OK/HDR_OVF defaults, the frame byte-count function (DW/8 + 1).
- Single flat module. The shift register plus byte counter may be factored as sub-module byte_serializer (load, shift, last outputs) if reused by the hex-dump variant.

Test Plan:
- Single entry 48'h0123_4567_89AB, UART model with 10-cycle busy -> bytes A5,01,23,45,67,89,AB; exactly one rb_read_enable; frame_count=1; active low afterwards.
- Three entries queued back-to-back -> 21 bytes in FIFO order; 3 pops, each only after the previous frame's last byte; frame_count=3.
- rb_overflow pulsed once before the second frame is latched -> frame 2 header 5A, frame 3 header A5.
- rb_empty=1 throughout for 1000 cycles -> no rb_read_enable and no tx_start; all outputs at reset values.
- Reset asserted after the 3rd byte of a frame -> next cycle tx_start=0, active=0, frame_count=0. A fresh entry afterwards sends a full 7 bytes starting with A5.
- tx_busy held high for 500 cycles while in SEND -> tx_data is not yet driven and no tx_start is issued. tx_start fires the first cycle busy is low; no byte is lost or duplicated.

Source files
------------

// File: rtl/ringbuffer_drain_pkg.sv
// Shared definitions for the ring buffer drain path: FSM encoding, default
// header bytes and the frame length helper.
package ringbuffer_drain_pkg;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_POP   = 3'd1;
   localparam logic [2:0] S_LATCH = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_ACK   = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   localparam int         DW_DEFAULT      = 48;
   localparam logic [7:0] HDR_OK_DEFAULT  = 8'hA5;
   localparam logic [7:0] HDR_OVF_DEFAULT = 8'h5A;

   // UART bytes per frame: one header plus the payload bytes.
   function automatic int frame_bytes(input int dw);
      return dw / 8 + 1;
   endfunction

endpackage

// File: rtl/ringbuffer_drain_serializer.sv
// Header-plus-payload shift register for the drain path. Presents the current
// byte MSB-first and flags when it is the last byte of the frame.
module ringbuffer_drain_serializer
   import ringbuffer_drain_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic          shift_i,
   input  logic [7:0]    hdr_i,
   input  logic [DW-1:0] data_i,
   output logic [7:0]    byte_o,
   output logic          last_o
);

   localparam int CW = $clog2(frame_bytes(DW));

   logic [DW+7:0] shreg_q, shreg_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter holds the number of bytes still to follow the current one.
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shreg_d = {hdr_i, data_i};
         cnt_d   = CW'(frame_bytes(DW) - 1);
      end else if (shift_i && (cnt_q != '0)) begin
         shreg_d = {shreg_q[DW-1:0], 8'h00};
         cnt_d   = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign byte_o = shreg_q[DW+7:DW];
   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/ringbuffer_drain.sv
// Pops frames from the sniffer ring buffer and feeds them byte by byte to the
// UART, prefixing each with a header that flags an intervening overflow.
module ringbuffer_drain
   import ringbuffer_drain_pkg::*;
#(
   parameter int         DW      = DW_DEFAULT,
   parameter logic [7:0] HDR_OK  = HDR_OK_DEFAULT,
   parameter logic [7:0] HDR_OVF = HDR_OVF_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          rb_empty,
   input  logic          rb_overflow,
   input  logic [DW-1:0] rb_read_data,
   output logic          rb_read_enable,
   input  logic          tx_busy,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   output logic          active,
   output logic [15:0]   frame_count
);

   state_t      state_q, state_d;
   logic        rd_en_q, rd_en_d;
   logic        tx_start_q, tx_start_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        active_q, active_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic        ovf_q, ovf_d;

   logic        ser_load;
   logic        ser_shift;
   logic [7:0]  ser_byte;
   logic        ser_last;
   logic [7:0]  hdr_sel;

   assign hdr_sel = ovf_q ? HDR_OVF : HDR_OK;

   ringbuffer_drain_serializer #(
      .DW (DW)
   ) u_ser (
      .clk     (clk),
      .reset   (reset),
      .load_i  (ser_load),
      .shift_i (ser_shift),
      .hdr_i   (hdr_sel),
      .data_i  (rb_read_data),
      .byte_o  (ser_byte),
      .last_o  (ser_last)
   );

   always_comb begin
      state_d    = state_q;
      rd_en_d    = 1'b0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      active_d   = active_q;
      fcnt_d     = fcnt_q;
      ovf_d      = ovf_q | rb_overflow;
      ser_load   = 1'b0;
      ser_shift  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enable && !rb_empty) begin
               rd_en_d  = 1'b1;
               active_d = 1'b1;
               state_d  = S_POP;
            end
         end
         S_POP: begin
            state_d = S_LATCH;
         end
         // An overflow arriving in the consuming cycle must survive the clear.
         S_LATCH: begin
            ser_load = 1'b1;
            ovf_d    = rb_overflow;
            state_d  = S_SEND;
         end
         S_SEND: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = ser_byte;
               state_d    = S_ACK;
            end
         end
         S_ACK: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!tx_busy) begin
               if (!ser_last) begin
                  ser_shift = 1'b1;
                  state_d   = S_SEND;
               end else begin
                  fcnt_d   = fcnt_q + 16'd1;
                  active_d = 1'b0;
                  state_d  = S_IDLE;
               end
            end
         end
         default: begin
            state_d  = S_IDLE;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rd_en_q    <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         active_q   <= 1'b0;
         fcnt_q     <= 16'h0000;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_en_q    <= rd_en_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         active_q   <= active_d;
         fcnt_q     <= fcnt_d;
         ovf_q      <= ovf_d;
      end
   end

   assign rb_read_enable = rd_en_q;
   assign tx_start       = tx_start_q;
   assign tx_data        = tx_data_q;
   assign active         = active_q;
   assign frame_count    = fcnt_q;

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Directed bench for ringbuffer_drain with a queue-based ring buffer and a
// 10-cycle-busy UART model.
module tb_ringbuffer_drain;

   localparam int DW = 48;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b1;
   logic          rb_empty = 1'b1;
   logic          rb_overflow = 1'b0;
   logic [DW-1:0] rb_read_data = '0;
   logic          rb_read_enable;
   logic          tx_busy;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          active;
   logic [15:0]   frame_count;

   logic [DW-1:0] rb_q[$];
   logic [7:0]    byte_log[$];
   int            pop_bytes[$];
   int            pop_cnt = 0;
   int            bad_pop = 0;
   int            busy_cnt = 0;
   logic          force_busy = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   ringbuffer_drain #(.DW(DW)) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .rb_empty       (rb_empty),
      .rb_overflow    (rb_overflow),
      .rb_read_data   (rb_read_data),
      .rb_read_enable (rb_read_enable),
      .tx_busy        (tx_busy),
      .tx_start       (tx_start),
      .tx_data        (tx_data),
      .active         (active),
      .frame_count    (frame_count)
   );

   // Ring buffer model: registered read data, empty flag refreshed each negedge.
   always @(posedge clk) begin
      if (rb_read_enable) begin
         pop_cnt <= pop_cnt + 1;
         pop_bytes.push_back(byte_log.size());
         if (rb_q.size() == 0) bad_pop <= bad_pop + 1;
         else rb_read_data <= rb_q.pop_front();
      end
   end

   always @(negedge clk) rb_empty <= (rb_q.size() == 0);

   // UART model: busy for 10 cycles after each accepted start.
   assign tx_busy = (busy_cnt != 0) || force_busy;

   always @(posedge clk) begin
      if (reset) busy_cnt <= 0;
      else if (tx_start) begin
         busy_cnt <= 10;
         byte_log.push_back(tx_data);
      end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_entry(input logic [DW-1:0] d);
      rb_q.push_back(d);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      enable = 1'b1;
      rb_overflow = 1'b0;
      force_busy = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_frames(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (frame_count == 16'(n)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_bytes(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (byte_log.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++; if (rb_read_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b want 0", rb_read_enable); end
      tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      tests_run++; if (active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b want 0", active); end
      tests_run++; if (frame_count !== 16'h0000) begin tests_failed++; $display("FAIL reset_frame_count: got %h want 0000", frame_count); end
      reset = 1'b0;
   endtask

   task automatic test_single;
      int b0, p0;
      bit ok;
      logic [7:0] exp[7];
      exp = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
      do_reset;
      b0 = byte_log.size();
      p0 = pop_cnt;
      push_entry(48'h0123_4567_89AB);
      wait_frames(1, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL single_timeout: frame_count %0d want 1", frame_count); end
      repeat (5) @(negedge clk);
      tests_run++; if (byte_log.size() !== b0 + 7) begin tests_failed++; $display("FAIL single_nbytes: got %0d want %0d", byte_log.size() - b0, 7); end
      for (int i = 0; i < 7; i++) begin
         tests_run++; if (byte_log[b0+i] !== exp[i]) begin tests_failed++; $display("FAIL single_byte%0d: got %h want %h", i, byte_log[b0+i], exp[i]); end
      end
      tests_run++; if (pop_cnt !== p0 + 1) begin tests_failed++; $display("FAIL single_pops: got %0d want 1", pop_cnt - p0); end
      tests_run++; if (frame_count !== 16'd1) begin tests_failed++; $display("FAIL single_frame_count: got %0d want 1", frame_count); end
      tests_run++; if (active !== 1'b0) begin tests_failed++; $display("FAIL single_active: got %b want 0", active); end
   endtask

   task automatic test_back_to_back;
      int b0, p0;
      bit ok;
      logic [7:0] exp[21];
      exp = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
              8'hA5, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6,
              8'hA5, 8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A};
      do_reset;
      b0 = byte_log.size();
      p0 = pop_cnt;
      push_entry(48'h1020_3040_5060);
      push_entry(48'hA1B2_C3D4_E5F6);
      push_entry(48'h0F1E_2D3C_4B5A);
      wait_frames(3, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_timeout: frame_count %0d want 3", frame_count); end
      repeat (5) @(negedge clk);
      tests_run++; if (byte_log.size() !== b0 + 21) begin tests_failed++; $display("FAIL b2b_nbytes: got %0d want 21", byte_log.size() - b0); end
      for (int i = 0; i < 21; i++) begin
         tests_run++; if (byte_log[b0+i] !== exp[i]) begin tests_failed++; $display("FAIL b2b_byte%0d: got %h want %h", i, byte_log[b0+i], exp[i]); end
      end
      tests_run++; if (pop_cnt !== p0 + 3) begin tests_failed++; $display("FAIL b2b_pops: got %0d want 3", pop_cnt - p0); end
      for (int i = 0; i < 3; i++) begin
         tests_run++; if (pop_bytes[p0+i] - b0 !== 7 * i) begin tests_failed++; $display("FAIL b2b_pop%0d_order: bytes before pop %0d want %0d", i, pop_bytes[p0+i] - b0, 7 * i); end
      end
      tests_run++; if (frame_count !== 16'd3) begin tests_failed++; $display("FAIL b2b_frame_count: got %0d want 3", frame_count); end
      tests_run++; if (bad_pop !== 0) begin tests_failed++; $display("FAIL b2b_pop_when_empty: got %0d want 0", bad_pop); end
   endtask

   task automatic test_overflow;
      int b0;
      bit ok;
      do_reset;
      b0 = byte_log.size();
      push_entry(48'h1111_1111_1111);
      wait_bytes(b0 + 1, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL ovf_first_byte_timeout: got %0d bytes want 1", byte_log.size() - b0); end
      rb_overflow = 1'b1;
      @(negedge clk);
      rb_overflow = 1'b0;
      push_entry(48'h2222_2222_2222);
      push_entry(48'h3333_3333_3333);
      wait_frames(3, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL ovf_timeout: frame_count %0d want 3", frame_count); end
      tests_run++; if (byte_log[b0] !== 8'hA5) begin tests_failed++; $display("FAIL ovf_hdr1: got %h want A5", byte_log[b0]); end
      tests_run++; if (byte_log[b0+7] !== 8'h5A) begin tests_failed++; $display("FAIL ovf_hdr2: got %h want 5A", byte_log[b0+7]); end
      tests_run++; if (byte_log[b0+8] !== 8'h22) begin tests_failed++; $display("FAIL ovf_payload2: got %h want 22", byte_log[b0+8]); end
      tests_run++; if (byte_log[b0+14] !== 8'hA5) begin tests_failed++; $display("FAIL ovf_hdr3: got %h want A5", byte_log[b0+14]); end
   endtask

   task automatic test_empty_idle;
      int b0, p0;
      do_reset;
      b0 = byte_log.size();
      p0 = pop_cnt;
      repeat (1000) @(negedge clk);
      tests_run++; if (pop_cnt !== p0) begin tests_failed++; $display("FAIL empty_pops: got %0d want 0", pop_cnt - p0); end
      tests_run++; if (byte_log.size() !== b0) begin tests_failed++; $display("FAIL empty_starts: got %0d want 0", byte_log.size() - b0); end
      tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL empty_tx_data: got %h want 00", tx_data); end
      tests_run++; if (active !== 1'b0) begin tests_failed++; $display("FAIL empty_active: got %b want 0", active); end
      tests_run++; if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL empty_frame_count: got %0d want 0", frame_count); end
   endtask

   task automatic test_reset_midframe;
      int b0, b1;
      bit ok;
      logic [7:0] exp[7];
      exp = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE};
      do_reset;
      b0 = byte_log.size();
      push_entry(48'h5555_6666_7777);
      wait_bytes(b0 + 3, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL midrst_timeout: got %0d bytes want 3", byte_log.size() - b0); end
      reset = 1'b1;
      @(negedge clk);
      tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL midrst_tx_start: got %b want 0", tx_start); end
      tests_run++; if (active !== 1'b0) begin tests_failed++; $display("FAIL midrst_active: got %b want 0", active); end
      tests_run++; if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL midrst_frame_count: got %0d want 0", frame_count); end
      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      tests_run++; if (byte_log.size() !== b0 + 3) begin tests_failed++; $display("FAIL midrst_extra_bytes: got %0d want 3", byte_log.size() - b0); end
      b1 = byte_log.size();
      push_entry(48'hDEAD_BEEF_CAFE);
      wait_frames(1, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL midrst_fresh_timeout: frame_count %0d want 1", frame_count); end
      repeat (5) @(negedge clk);
      tests_run++; if (byte_log.size() !== b1 + 7) begin tests_failed++; $display("FAIL midrst_fresh_nbytes: got %0d want 7", byte_log.size() - b1); end
      for (int i = 0; i < 7; i++) begin
         tests_run++; if (byte_log[b1+i] !== exp[i]) begin tests_failed++; $display("FAIL midrst_byte%0d: got %h want %h", i, byte_log[b1+i], exp[i]); end
      end
   endtask

   task automatic test_busy_hold;
      int b0;
      bit ok;
      logic [7:0] exp[7];
      exp = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
      do_reset;
      force_busy = 1'b1;
      b0 = byte_log.size();
      push_entry(48'h0123_4567_89AB);
      repeat (500) @(negedge clk);
      tests_run++; if (byte_log.size() !== b0) begin tests_failed++; $display("FAIL busy_early_start: got %0d bytes want 0", byte_log.size() - b0); end
      tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL busy_tx_start: got %b want 0", tx_start); end
      tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL busy_tx_data: got %h want 00", tx_data); end
      tests_run++; if (active !== 1'b1) begin tests_failed++; $display("FAIL busy_active: got %b want 1", active); end
      force_busy = 1'b0;
      @(negedge clk);
      tests_run++; if (tx_start !== 1'b1) begin tests_failed++; $display("FAIL busy_release_start: got %b want 1", tx_start); end
      tests_run++; if (tx_data !== 8'hA5) begin tests_failed++; $display("FAIL busy_release_data: got %h want A5", tx_data); end
      wait_frames(1, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL busy_timeout: frame_count %0d want 1", frame_count); end
      repeat (5) @(negedge clk);
      tests_run++; if (byte_log.size() !== b0 + 7) begin tests_failed++; $display("FAIL busy_nbytes: got %0d want 7", byte_log.size() - b0); end
      for (int i = 0; i < 7; i++) begin
         tests_run++; if (byte_log[b0+i] !== exp[i]) begin tests_failed++; $display("FAIL busy_byte%0d: got %h want %h", i, byte_log[b0+i], exp[i]); end
      end
   endtask

   task automatic test_enable;
      int b0, p0;
      bit ok;
      do_reset;
      b0 = byte_log.size();
      p0 = pop_cnt;
      push_entry(48'hAAAA_BBBB_CCCC);
      push_entry(48'h1234_5678_9ABC);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pop_cnt == p0 + 1) begin
            ok = 1'b1;
            break;
         end
      end
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL enable_first_pop: got %0d pops want 1", pop_cnt - p0); end
      enable = 1'b0;
      wait_frames(1, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL enable_complete: frame_count %0d want 1", frame_count); end
      repeat (50) @(negedge clk);
      tests_run++; if (pop_cnt !== p0 + 1) begin tests_failed++; $display("FAIL enable_held_pops: got %0d want 1", pop_cnt - p0); end
      tests_run++; if (byte_log.size() !== b0 + 7) begin tests_failed++; $display("FAIL enable_held_bytes: got %0d want 7", byte_log.size() - b0); end
      enable = 1'b1;
      wait_frames(2, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL enable_resume: frame_count %0d want 2", frame_count); end
      tests_run++; if (pop_cnt !== p0 + 2) begin tests_failed++; $display("FAIL enable_resume_pops: got %0d want 2", pop_cnt - p0); end
      tests_run++; if (byte_log[b0+8] !== 8'h12) begin tests_failed++; $display("FAIL enable_frame2_byte1: got %h want 12", byte_log[b0+8]); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_overflow;
      test_empty_idle;
      test_reset_midframe;
      test_busy_hold;
      test_enable;
      tests_run++; if (bad_pop !== 0) begin tests_failed++; $display("FAIL pop_when_empty_total: got %0d want 0", bad_pop); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
